// File: rtl/risc_v_multi_controller_if.sv
// Control bus between the multi-cycle RISC-V controller and its datapath.
// The controller (master) reads the latched instruction and ALU flags and
// drives every datapath select/enable; the datapath (slave) does the reverse.
interface risc_v_multi_controller_if;
    logic [31:0] instruct;
    logic        zero;
    logic        neg;
    logic        pc_load;
    logic        adrsrc;
    logic        IRload;
    logic        regwe;
    logic        lui;
    logic        memwrite;
    logic [1:0]  resultsrc;
    logic [1:0]  alusrcA;
    logic [1:0]  alusrcB;
    logic [2:0]  imm_src;
    logic [2:0]  alu_control;
    logic        illegal;
    logic [3:0]  state_out;

    modport master (
        input  instruct, zero, neg,
        output pc_load, adrsrc, IRload, regwe, lui, memwrite,
               resultsrc, alusrcA, alusrcB, imm_src, alu_control,
               illegal, state_out
    );

    modport slave (
        output instruct, zero, neg,
        input  pc_load, adrsrc, IRload, regwe, lui, memwrite,
               resultsrc, alusrcA, alusrcB, imm_src, alu_control,
               illegal, state_out
    );
endinterface

// File: rtl/risc_v_multi_controller.sv
// Multi-cycle RISC-V control unit: Moore state sequencing with Mealy decode
// of opcode/funct. Legality of an instruction is settled once, in DECODE.
module risc_v_multi_controller #(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic clk,
    input  logic rst,
    risc_v_multi_controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_R    = 4'd2,
        EXEC_I    = 4'd3,
        ALU_WB    = 4'd4,
        MEM_ADR   = 4'd5,
        MEM_READ  = 4'd6,
        MEM_WB    = 4'd7,
        MEM_WRITE = 4'd8,
        BRANCH    = 4'd9,
        JAL       = 4'd10,
        JALR      = 4'd11,
        LUI       = 4'd12,
        HALT      = 4'd13
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    state_t     state;
    state_t     next_state;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [2:0] f3_alu;
    logic       f3_alu_ok;
    logic [2:0] r_alu;
    logic       r_ok;
    logic       instr_ok;
    logic       branch_taken;

    assign opcode        = bus.instruct[6:0];
    assign funct3        = bus.instruct[14:12];
    assign funct7        = bus.instruct[31:25];
    assign bus.state_out = state;

    // funct3 -> ALU op, shared by register and immediate arithmetic
    always_comb begin
        f3_alu    = ALU_ADD;
        f3_alu_ok = 1'b1;
        case (funct3)
            3'b000:  f3_alu = ALU_ADD;
            3'b111:  f3_alu = ALU_AND;
            3'b110:  f3_alu = ALU_OR;
            3'b010:  f3_alu = ALU_SLT;
            3'b100:  f3_alu = ALU_XOR;
            default: f3_alu_ok = 1'b0;
        endcase
    end

    // R-type also qualifies funct7; only sub uses 0100000
    always_comb begin
        r_alu = f3_alu;
        r_ok  = 1'b0;
        if (funct7 == 7'b0000000) begin
            r_ok = f3_alu_ok;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
            r_alu = ALU_SUB;
            r_ok  = 1'b1;
        end
    end

    // Whole-instruction legality, consumed in DECODE
    always_comb begin
        case (opcode)
            OP_R:                    instr_ok = r_ok;
            OP_I:                    instr_ok = f3_alu_ok;
            OP_LOAD, OP_STORE:       instr_ok = (funct3 == 3'b010);
            OP_BRANCH:               instr_ok = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                                                (funct3 == 3'b100) || (funct3 == 3'b101);
            OP_JAL, OP_JALR, OP_LUI: instr_ok = 1'b1;
            default:                 instr_ok = 1'b0;
        endcase
    end

    // Branch condition from the live ALU flags (neg is not overflow-corrected)
    always_comb begin
        case (funct3)
            3'b000:  branch_taken = bus.zero;
            3'b001:  branch_taken = !bus.zero;
            3'b100:  branch_taken = bus.neg;
            3'b101:  branch_taken = !bus.neg;
            default: branch_taken = 1'b0;
        endcase
    end

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= next_state;
    end

    // Next state and per-state outputs; reset masks every enable
    always_comb begin
        next_state      = FETCH;
        bus.pc_load     = 1'b0;
        bus.adrsrc      = 1'b0;
        bus.IRload      = 1'b0;
        bus.regwe       = 1'b0;
        bus.lui         = 1'b0;
        bus.memwrite    = 1'b0;
        bus.illegal     = 1'b0;
        bus.resultsrc   = 2'b00;
        bus.alusrcA     = 2'b00;
        bus.alusrcB     = 2'b00;
        bus.imm_src     = IMM_I;
        bus.alu_control = ALU_ADD;
        case (state)
            FETCH: begin
                bus.IRload    = 1'b1;
                bus.pc_load   = 1'b1;
                bus.alusrcB   = 2'b10;
                bus.resultsrc = 2'b10;
                next_state    = DECODE;
            end
            DECODE: begin
                // ALU register captures old_pc + imm for branch/jal targets
                bus.alusrcA = 2'b01;
                bus.alusrcB = 2'b01;
                if (opcode == OP_BRANCH)   bus.imm_src = IMM_B;
                else if (opcode == OP_JAL) bus.imm_src = IMM_J;
                // Link write: ALU register still holds PC+4 from FETCH
                if (opcode == OP_JAL || opcode == OP_JALR) bus.regwe = 1'b1;
                if (!instr_ok) begin
                    bus.illegal = 1'b1;
                    next_state  = ILLEGAL_TRAP ? HALT : FETCH;
                end else begin
                    case (opcode)
                        OP_R:              next_state = EXEC_R;
                        OP_I:              next_state = EXEC_I;
                        OP_LOAD, OP_STORE: next_state = MEM_ADR;
                        OP_BRANCH:         next_state = BRANCH;
                        OP_JAL:            next_state = JAL;
                        OP_JALR:           next_state = JALR;
                        default:           next_state = LUI;
                    endcase
                end
            end
            EXEC_R: begin
                bus.alusrcA     = 2'b10;
                bus.alu_control = r_alu;
                next_state      = ALU_WB;
            end
            EXEC_I: begin
                bus.alusrcA     = 2'b10;
                bus.alusrcB     = 2'b01;
                bus.alu_control = f3_alu;
                next_state      = ALU_WB;
            end
            ALU_WB: begin
                bus.regwe = 1'b1;
            end
            MEM_ADR: begin
                bus.alusrcA = 2'b10;
                bus.alusrcB = 2'b01;
                if (opcode == OP_STORE) begin
                    bus.imm_src = IMM_S;
                    next_state  = MEM_WRITE;
                end else begin
                    next_state  = MEM_READ;
                end
            end
            MEM_READ: begin
                bus.adrsrc  = 1'b1;
                bus.alusrcA = 2'b10;
                bus.alusrcB = 2'b01;
                next_state  = MEM_WB;
            end
            MEM_WB: begin
                bus.regwe     = 1'b1;
                bus.resultsrc = 2'b01;
            end
            MEM_WRITE: begin
                bus.adrsrc   = 1'b1;
                bus.memwrite = 1'b1;
            end
            BRANCH: begin
                bus.alusrcA     = 2'b10;
                bus.alu_control = ALU_SUB;
                bus.pc_load     = branch_taken;
            end
            JAL: begin
                bus.pc_load = 1'b1;
            end
            JALR: begin
                bus.alusrcA   = 2'b10;
                bus.alusrcB   = 2'b01;
                bus.resultsrc = 2'b10;
                bus.pc_load   = 1'b1;
            end
            LUI: begin
                bus.lui     = 1'b1;
                bus.imm_src = IMM_U;
                bus.regwe   = 1'b1;
            end
            HALT: begin
                next_state = HALT;
            end
            default: next_state = FETCH;
        endcase
        if (rst) begin
            bus.pc_load  = 1'b0;
            bus.IRload   = 1'b0;
            bus.regwe    = 1'b0;
            bus.memwrite = 1'b0;
            bus.illegal  = 1'b0;
        end
    end
endmodule

// File: tb/tb_risc_v_multi_controller.sv
// Bench for risc_v_multi_controller: two instances (skip and trap on illegal)
// driven with the same instruction stream and compared every cycle against a
// per-instruction expected-output sequence derived from the instruction rules.
module tb_risc_v_multi_controller;
    typedef struct packed {
        logic [3:0] st;
        logic       pc_load;
        logic       adrsrc;
        logic       irload;
        logic       regwe;
        logic       lui;
        logic       memwrite;
        logic       illegal;
        logic [1:0] res;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [2:0] imm;
        logic [2:0] alu;
    } ctl_t;

    localparam int CW = $bits(ctl_t);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   halted1 = 1'b0;
    logic [CW-1:0] exp_q[$];

    risc_v_multi_controller_if bus0();
    risc_v_multi_controller_if bus1();

    risc_v_multi_controller #(.ILLEGAL_TRAP(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    risc_v_multi_controller #(.ILLEGAL_TRAP(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    ctl_t got0;
    ctl_t got1;
    assign got0 = {bus0.state_out, bus0.pc_load, bus0.adrsrc, bus0.IRload, bus0.regwe, bus0.lui,
                   bus0.memwrite, bus0.illegal, bus0.resultsrc, bus0.alusrcA, bus0.alusrcB,
                   bus0.imm_src, bus0.alu_control};
    assign got1 = {bus1.state_out, bus1.pc_load, bus1.adrsrc, bus1.IRload, bus1.regwe, bus1.lui,
                   bus1.memwrite, bus1.illegal, bus1.resultsrc, bus1.alusrcA, bus1.alusrcB,
                   bus1.imm_src, bus1.alu_control};

    // clock / reset block
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ALU op by mnemonic table; -1 marks an unsupported funct combination
    function automatic int alu_of(input logic [31:0] ins, input bit is_r);
        logic [2:0] f3;
        logic [6:0] f7;
        int op;
        f3 = ins[14:12];
        f7 = ins[31:25];
        case (f3)
            3'b000:  op = 0;   // add
            3'b111:  op = 2;   // and
            3'b110:  op = 3;   // or
            3'b010:  op = 4;   // slt
            3'b100:  op = 5;   // xor
            default: op = -1;
        endcase
        if (is_r) begin
            if (f7 == 7'b0100000) op = (f3 == 3'b000) ? 1 : -1;
            else if (f7 != 7'b0000000) op = -1;
        end
        return op;
    endfunction

    // 0 illegal, 1 R, 2 I, 3 lw, 4 sw, 5 branch, 6 jal, 7 jalr, 8 lui
    function automatic int kind_of(input logic [31:0] ins);
        int f3;
        f3 = int'(ins[14:12]);
        case (ins[6:0])
            7'b0110011: return (alu_of(ins, 1'b1) >= 0) ? 1 : 0;
            7'b0010011: return (alu_of(ins, 1'b0) >= 0) ? 2 : 0;
            7'b0000011: return (f3 == 2) ? 3 : 0;
            7'b0100011: return (f3 == 2) ? 4 : 0;
            7'b1100011: return (f3 == 0 || f3 == 1 || f3 == 4 || f3 == 5) ? 5 : 0;
            7'b1101111: return 6;
            7'b1100111: return 7;
            7'b0110111: return 8;
            default:    return 0;
        endcase
    endfunction

    // Expected output of every cycle the instruction occupies, FETCH first
    task automatic build_seq(input logic [31:0] ins, input logic z, input logic n);
        ctl_t c;
        int   k;
        int   op;
        int   f3;
        k  = kind_of(ins);
        f3 = int'(ins[14:12]);
        c = '0; c.irload = 1; c.pc_load = 1; c.srcb = 2; c.res = 2;
        exp_q.push_back(c);
        c = '0; c.st = 1; c.srca = 1; c.srcb = 1;
        if (ins[6:0] == 7'b1100011) c.imm = 2;
        else if (ins[6:0] == 7'b1101111) c.imm = 3;
        if (k == 6 || k == 7) c.regwe = 1;
        if (k == 0) c.illegal = 1;
        exp_q.push_back(c);
        case (k)
            1, 2: begin
                op = alu_of(ins, k == 1);
                c = '0; c.st = (k == 1) ? 4'd2 : 4'd3; c.srca = 2; c.srcb = (k == 1) ? 2'd0 : 2'd1;
                c.alu = op[2:0];
                exp_q.push_back(c);
                c = '0; c.st = 4; c.regwe = 1;
                exp_q.push_back(c);
            end
            3: begin
                c = '0; c.st = 5; c.srca = 2; c.srcb = 1; exp_q.push_back(c);
                c = '0; c.st = 6; c.srca = 2; c.srcb = 1; c.adrsrc = 1; exp_q.push_back(c);
                c = '0; c.st = 7; c.regwe = 1; c.res = 1; exp_q.push_back(c);
            end
            4: begin
                c = '0; c.st = 5; c.srca = 2; c.srcb = 1; c.imm = 1; exp_q.push_back(c);
                c = '0; c.st = 8; c.adrsrc = 1; c.memwrite = 1; exp_q.push_back(c);
            end
            5: begin
                c = '0; c.st = 9; c.srca = 2; c.alu = 1;
                c.pc_load = (f3 == 0) ? z : (f3 == 1) ? !z : (f3 == 4) ? n : !n;
                exp_q.push_back(c);
            end
            6: begin
                c = '0; c.st = 10; c.pc_load = 1; exp_q.push_back(c);
            end
            7: begin
                c = '0; c.st = 11; c.srca = 2; c.srcb = 1; c.res = 2; c.pc_load = 1;
                exp_q.push_back(c);
            end
            8: begin
                c = '0; c.st = 12; c.lui = 1; c.imm = 4; c.regwe = 1; exp_q.push_back(c);
            end
            default: ;
        endcase
    endtask

    // Driver: present one instruction in FETCH and check up to max_steps cycles
    task automatic run_instr(input logic [31:0] ins, input logic z, input logic n, input int max_steps);
        ctl_t e;
        ctl_t h;
        int   k;
        int   i;
        bus0.instruct = ins; bus1.instruct = ins;
        bus0.zero = z; bus1.zero = z;
        bus0.neg = n; bus1.neg = n;
        k = kind_of(ins);
        build_seq(ins, z, n);
        h = '0; h.st = 4'd13;
        i = 0;
        while (exp_q.size() > 0 && i < max_steps) begin
            e = exp_q.pop_front();
            @(negedge clk);
            check_eq($sformatf("skip %h c%0d", ins, i), got0, e);
            check_eq($sformatf("trap %h c%0d", ins, i), got1, halted1 ? h : e);
            @(posedge clk); #1;
            i++;
        end
        if (k == 0 && i >= 2) halted1 = 1'b1;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("rst_hold_state", bus0.state_out, 32'd0);
        check_eq("rst_hold_en", {bus0.pc_load, bus0.IRload, bus0.regwe, bus0.memwrite, bus0.illegal}, 32'd0);
        check_eq("rst_hold_en_trap", {bus1.pc_load, bus1.IRload, bus1.regwe, bus1.memwrite, bus1.illegal}, 32'd0);
        rst = 1'b0;
        halted1 = 1'b0;
        #1;
        check_eq("rst_state", bus0.state_out, 32'd0);
        check_eq("rst_irload", bus0.IRload, 32'd1);
        check_eq("rst_pc_load", bus0.pc_load, 32'd1);
        check_eq("rst_alusrcb", bus0.alusrcB, 32'd2);
        check_eq("rst_resultsrc", bus0.resultsrc, 32'd2);
        check_eq("rst_we", {bus0.regwe, bus0.memwrite}, 32'd0);
        check_eq("rst_state_trap", bus1.state_out, 32'd0);
    endtask

    initial begin
        bus0.instruct = '0; bus1.instruct = '0;
        bus0.zero = 1'b0; bus1.zero = 1'b0;
        bus0.neg = 1'b0; bus1.neg = 1'b0;
        do_reset();

        // directed cases
        run_instr(32'h002081B3, 1'b0, 1'b0, 99);  // add
        run_instr(32'h402081B3, 1'b0, 1'b0, 99);  // sub
        run_instr(32'h0080A283, 1'b0, 1'b0, 99);  // lw
        run_instr(32'h0050A623, 1'b0, 1'b0, 99);  // sw
        run_instr(32'h00208463, 1'b1, 1'b0, 99);  // beq taken
        run_instr(32'h00208463, 1'b0, 1'b0, 99);  // beq not taken
        run_instr(32'h00209463, 1'b1, 1'b0, 99);  // bne not taken
        run_instr(32'h00209463, 1'b0, 1'b0, 99);  // bne taken
        run_instr(32'h0020C463, 1'b0, 1'b1, 99);  // blt taken
        run_instr(32'h0020D463, 1'b0, 1'b1, 99);  // bge not taken
        run_instr(32'h010000EF, 1'b0, 1'b0, 99);  // jal
        run_instr(32'h000080E7, 1'b0, 1'b0, 99);  // jalr
        run_instr(32'h123452B7, 1'b0, 1'b0, 99);  // lui
        run_instr(32'h00508093, 1'b0, 1'b0, 99);  // addi
        run_instr(32'h0000F093, 1'b0, 1'b0, 99);  // andi
        run_instr(32'h00001093, 1'b0, 1'b0, 99);  // slli: unsupported
        run_instr(32'hFFFFFFFF, 1'b0, 1'b0, 99);  // unsupported opcode
        run_instr(32'h002081B3, 1'b0, 1'b0, 99);  // trap instance must stay halted
        run_instr(32'h0050A623, 1'b0, 1'b0, 99);

        // reset in MEM_READ aborts the load with no register write
        do_reset();
        run_instr(32'h0080A283, 1'b0, 1'b0, 3);
        rst = 1'b1;
        #1;
        check_eq("abort_state", bus0.state_out, 32'd6);
        check_eq("abort_en", {bus0.pc_load, bus0.IRload, bus0.regwe, bus0.memwrite, bus0.illegal}, 32'd0);
        @(posedge clk); #1;
        check_eq("abort_next", bus0.state_out, 32'd0);
        check_eq("abort_regwe", bus0.regwe, 32'd0);
        rst = 1'b0;
        halted1 = 1'b0;
        #1;

        // randomized stream
        for (int t = 0; t < 120; t++) begin
            logic [6:0]  op;
            logic [6:0]  f7;
            logic [31:0] ins;
            case ($urandom_range(0, 9))
                0:       op = 7'b0110011;
                1:       op = 7'b0010011;
                2:       op = 7'b0000011;
                3:       op = 7'b0100011;
                4:       op = 7'b1100011;
                5:       op = 7'b1101111;
                6:       op = 7'b1100111;
                7:       op = 7'b0110111;
                8:       op = 7'($urandom);
                default: op = 7'b0110011;
            endcase
            if ($urandom_range(0, 3) == 0) f7 = 7'($urandom);
            else f7 = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000;
            ins = {f7, 10'($urandom), 3'($urandom), 5'($urandom), op};
            if ($urandom_range(0, 11) == 0) do_reset();
            run_instr(ins, 1'($urandom), 1'($urandom), 99);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/risc_v_multi_controller.md
Name: risc_v_multi_controller

Overview:
- Control unit for the multi-cycle RISC-V datapath.
- Consumes the latched instruction and the ALU zero/neg flags, and drives every datapath select and enable, plus the memory write enable.
- Implemented as a Moore FSM with Mealy decode on opcode/funct. One instruction completes per 3–5 cycles.

Parameters:
ILLEGAL_TRAP, 0, 0: unsupported instruction is skipped; 1: FSM enters HALT until reset.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
instruct  input  32  instruction register contents
zero  input  1  ALU result == 0 (combinational)
neg  input  1  ALU result bit 31 (combinational)
pc_load  output  1  PC write enable
adrsrc  output  1  memory address select: 0 PC, 1 result
IRload  output  1  instruction register write enable
regwe  output  1  register file write enable
lui  output  1  regfile write data select: 0 result, 1 immediate
memwrite  output  1  data memory write enable
resultsrc  output  2  00 ALU register, 01 memory data register, 10 ALU combinational
alusrcA  output  2  00 PC, 01 old PC, 10 register A
alusrcB  output  2  00 register B, 01 immediate, 10 constant 4
imm_src  output  3  000 I, 001 S, 010 B, 011 J, 100 U
alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor
illegal  output  1  one-cycle pulse in DECODE for unsupported instruction
state_out  output  4  current state encoding, for verification

Behaviour:
- State encodings:
  - FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, ALU_WB 4
  - MEM_ADR 5, MEM_READ 6, MEM_WB 7, MEM_WRITE 8
  - BRANCH 9, JAL 10, JALR 11, LUI 12, HALT 13
- Reset: while rst=1, the next state is FETCH. All enables (pc_load, IRload, regwe, memwrite, illegal) are forced 0. A reset mid-instruction aborts it, with no further writes.
- Defaults, for every output not listed under a state: enables 0, lui 0, muxes 00, alu_control add, imm_src I.
- FETCH: IRload=1, pc_load=1, adrsrc=0, alusrcA=00, alusrcB=10, add, resultsrc=10. Next state DECODE.
- DECODE:
  - Outputs: alusrcA=01, alusrcB=01, add. ALU register captures old_pc+imm.
  - imm_src is B for branch, J for jal, else I.
  - For jal (1101111) and jalr (1100111): regwe=1, resultsrc=00. This writes rd <= PC+4, which the ALU register holds from FETCH. Register A latches the old rs1 at the same edge, so rd==rs1 is safe.
  - Next state by opcode:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 or 0100011 → MEM_ADR
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - anything else → illegal=1, then FETCH (ILLEGAL_TRAP=0) or HALT (ILLEGAL_TRAP=1).
- EXEC_R: alusrcA=10, alusrcB=00. Next state ALU_WB.
  - alu_control from funct7/funct3: 0000000/000 add, 0100000/000 sub, 111 and, 110 or, 010 slt, 100 xor.
  - Any other funct combination is illegal: decided in DECODE, same handling as an unsupported opcode.
- EXEC_I: alusrcA=10, alusrcB=01, imm I. Next state ALU_WB.
  - alu_control from funct3: 000 add, 111 and, 110 or, 010 slt, 100 xor. Other funct3 values are illegal.
- ALU_WB: regwe=1, resultsrc=00. Next state FETCH.
- MEM_ADR: alusrcA=10, alusrcB=01, add. imm_src is I for lw, S for sw.
  - Next state MEM_READ (lw) or MEM_WRITE (sw).
  - funct3≠010 is illegal.
- MEM_READ: adrsrc=1, resultsrc=00, plus MEM_ADR's ALU selects (address held). Next state MEM_WB.
- MEM_WB: regwe=1, resultsrc=01. Next state FETCH.
- MEM_WRITE: adrsrc=1, resultsrc=00, memwrite=1. Next state FETCH.
- BRANCH: alusrcA=10, alusrcB=00, sub, resultsrc=00.
  - pc_load per funct3: 000 beq → zero; 001 bne → !zero; 100 blt → neg; 101 bge → !neg.
  - Other funct3 values are illegal.
  - neg is not overflow-corrected; this is an accepted limitation.
  - Next state FETCH.
- JAL: pc_load=1, resultsrc=00 (target computed in DECODE). Next state FETCH.
- JALR: alusrcA=10, alusrcB=01, imm I, add, resultsrc=10, pc_load=1. Next state FETCH.
- LUI: lui=1, imm_src=U, regwe=1. Next state FETCH.
- HALT: all enables 0. Exits only on rst.
- Latency in cycles: R/I 4, lw 5, sw 4, branch 3, jal 3, jalr 3, lui 3.

Test Plan:
- Reset: rst=1 for 2 cycles, then release → state_out=0, IRload=1, pc_load=1, alusrcB=10, resultsrc=10, regwe=0, memwrite=0.
- add and sub:
  - instruct=0x002081B3 (add x3,x1,x2) → states 0,1,2,4,0; EXEC_R alu_control=000; ALU_WB regwe=1, resultsrc=00.
  - instruct=0x402081B3 (sub) → alu_control=001.
- Loads and stores:
  - instruct=0x0080A283 (lw) → states 0,1,5,6,7,0; MEM_READ adrsrc=1; MEM_WB resultsrc=01, regwe=1.
  - instruct=0x0050A623 (sw) → states 0,1,5,8,0; MEM_ADR imm_src=001; MEM_WRITE memwrite=1.
- Branches:
  - instruct=0x00208463 (beq): zero=1 → BRANCH pc_load=1; zero=0 → pc_load=0.
  - instruct=0x00209463 (bne) → pc_load is the inverse of the beq case.
- Jump:
  - instruct=0x010000EF (jal) → DECODE regwe=1, resultsrc=00, imm_src=011.
  - JAL state pc_load=1; returns to FETCH after 3 cycles.
- Error handling:
  - instruct=0xFFFFFFFF → illegal=1 in DECODE only; next state 0 with ILLEGAL_TRAP=0, state 13 (enables 0) with ILLEGAL_TRAP=1.
  - rst asserted during MEM_READ → next state 0, no regwe pulse.
